// File: rtl/vend_pkg.sv
// Shared vending definitions: coin values, coin-select encoding and dispenser states.
package vend_pkg;

   localparam int unsigned NICKEL_C  = 5;
   localparam int unsigned DIME_C    = 10;
   localparam int unsigned QUARTER_C = 25;

   typedef enum logic [1:0] {
      CoinNone,
      CoinNickel,
      CoinDime,
      CoinQuarter
   } coin_e;

   typedef enum logic [2:0] {
      StIdle,
      StSelect,
      StPulse,
      StGap,
      StDone
   } disp_state_e;

   // Face value in cents of a coin selection; CoinNone is worth nothing.
   function automatic int unsigned coin_value(input coin_e coin);
      int unsigned val;
      case (coin)
         CoinNickel:  val = NICKEL_C;
         CoinDime:    val = DIME_C;
         CoinQuarter: val = QUARTER_C;
         default:     val = 0;
      endcase
      return val;
   endfunction

endpackage

// File: rtl/eject_timer.sv
// Loadable down-counter with a terminal flag, used to time eject pulses and recovery gaps.
module eject_timer #(
   parameter int unsigned WIDTH = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic             tc
);

   logic [WIDTH-1:0] count_q;

   // Load wins; otherwise count down and park at zero.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count_q <= '0;
      end else if (load) begin
         count_q <= load_val;
      end else if (count_q != '0) begin
         count_q <= count_q - WIDTH'(1);
      end
   end

   assign tc = (count_q == '0);

endmodule

// File: rtl/change_dispenser.sv
// Coin-return payout engine: greedy quarter/dime/nickel ejection with per-tube stock tracking.
module change_dispenser
   import vend_pkg::*;
#(
   parameter int unsigned PULSE_CYCLES = 4,
   parameter int unsigned GAP_CYCLES   = 4,
   parameter int unsigned AMT_W        = 8,
   parameter int unsigned TUBE_W       = 6,
   parameter int unsigned TUBE_INIT    = 20
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [AMT_W-1:0] amount,
   input  logic             refill,
   output logic             quarterO,
   output logic             dimeO,
   output logic             nickelO,
   output logic             busy,
   output logic             done,
   output logic             short,
   output logic [AMT_W-1:0] remaining
);

   localparam int unsigned MAX_CYC = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
   localparam int unsigned TMR_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

   // The timer expires on the cycle its count reaches zero, so load N-1 for an N-cycle phase.
   localparam logic [TMR_W-1:0]  PULSE_LOAD = TMR_W'(PULSE_CYCLES - 1);
   localparam logic [TMR_W-1:0]  GAP_LOAD   = TMR_W'(GAP_CYCLES - 1);
   localparam logic [AMT_W-1:0]  Q_AMT      = AMT_W'(QUARTER_C);
   localparam logic [AMT_W-1:0]  D_AMT      = AMT_W'(DIME_C);
   localparam logic [AMT_W-1:0]  N_AMT      = AMT_W'(NICKEL_C);
   localparam logic [TUBE_W-1:0] TUBE_FULL  = TUBE_W'(TUBE_INIT);

   disp_state_e      state_q, state_d;
   coin_e            coin_q, coin_d;
   coin_e            sel_coin;
   logic [AMT_W-1:0] remaining_q, remaining_d;
   logic [TUBE_W-1:0] q_tube_q, q_tube_d;
   logic [TUBE_W-1:0] d_tube_q, d_tube_d;
   logic [TUBE_W-1:0] n_tube_q, n_tube_d;
   logic             timer_load;
   logic [TMR_W-1:0] timer_val;
   logic             timer_tc;

   eject_timer #(
      .WIDTH (TMR_W)
   ) u_eject_timer (
      .clk      (clk),
      .reset    (reset),
      .load     (timer_load),
      .load_val (timer_val),
      .tc       (timer_tc)
   );

   // Greedy pick: largest coin that fits the balance and is still stocked.
   always_comb begin
      sel_coin = CoinNone;
      if (remaining_q >= Q_AMT && q_tube_q != '0) begin
         sel_coin = CoinQuarter;
      end else if (remaining_q >= D_AMT && d_tube_q != '0) begin
         sel_coin = CoinDime;
      end else if (remaining_q >= N_AMT && n_tube_q != '0) begin
         sel_coin = CoinNickel;
      end
   end

   // Next-state, balance and tube bookkeeping.
   always_comb begin
      state_d     = state_q;
      coin_d      = coin_q;
      remaining_d = remaining_q;
      q_tube_d    = q_tube_q;
      d_tube_d    = d_tube_q;
      n_tube_d    = n_tube_q;
      timer_load  = 1'b0;
      timer_val   = PULSE_LOAD;

      case (state_q)
         StIdle: begin
            if (start) begin
               remaining_d = amount;
               state_d     = StSelect;
            end else if (refill) begin
               q_tube_d = TUBE_FULL;
               d_tube_d = TUBE_FULL;
               n_tube_d = TUBE_FULL;
            end
         end
         StSelect: begin
            if (sel_coin == CoinNone) begin
               state_d = StDone;
            end else begin
               state_d     = StPulse;
               coin_d      = sel_coin;
               timer_load  = 1'b1;
               timer_val   = PULSE_LOAD;
               // The greedy guards make this subtraction underflow-free.
               remaining_d = remaining_q - AMT_W'(coin_value(sel_coin));
               unique case (sel_coin)
                  CoinQuarter: if (q_tube_q != '0) q_tube_d = q_tube_q - TUBE_W'(1);
                  CoinDime:    if (d_tube_q != '0) d_tube_d = d_tube_q - TUBE_W'(1);
                  CoinNickel:  if (n_tube_q != '0) n_tube_d = n_tube_q - TUBE_W'(1);
                  default:     ;
               endcase
            end
         end
         StPulse: begin
            if (timer_tc) begin
               state_d    = StGap;
               timer_load = 1'b1;
               timer_val  = GAP_LOAD;
            end
         end
         StGap: begin
            if (timer_tc) begin
               state_d = StSelect;
               coin_d  = CoinNone;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // State, balance and tube registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= StIdle;
         coin_q      <= CoinNone;
         remaining_q <= '0;
         q_tube_q    <= TUBE_FULL;
         d_tube_q    <= TUBE_FULL;
         n_tube_q    <= TUBE_FULL;
      end else begin
         state_q     <= state_d;
         coin_q      <= coin_d;
         remaining_q <= remaining_d;
         q_tube_q    <= q_tube_d;
         d_tube_q    <= d_tube_d;
         n_tube_q    <= n_tube_d;
      end
   end

   // Outputs decode registered state only, so nothing is combinational from the inputs.
   assign quarterO  = (state_q == StPulse) && (coin_q == CoinQuarter);
   assign dimeO     = (state_q == StPulse) && (coin_q == CoinDime);
   assign nickelO   = (state_q == StPulse) && (coin_q == CoinNickel);
   assign busy      = (state_q != StIdle);
   assign done      = (state_q == StDone);
   assign short     = (state_q == StDone) && (remaining_q != '0);
   assign remaining = remaining_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Randomised self-checking bench for change_dispenser against a transaction-level payout model.
module tb_change_dispenser;

   localparam int P         = 4;
   localparam int G         = 4;
   localparam int SLOT      = 1 + P + G;
   localparam int TUBE_INIT = 20;

   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic [7:0] amount;
   logic       refill;
   logic       quarterO, dimeO, nickelO;
   logic       busy, done, short;
   logic [7:0] remaining;

   change_dispenser #(
      .PULSE_CYCLES (P),
      .GAP_CYCLES   (G),
      .AMT_W        (8),
      .TUBE_W       (6),
      .TUBE_INIT    (TUBE_INIT)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .amount    (amount),
      .refill    (refill),
      .quarterO  (quarterO),
      .dimeO     (dimeO),
      .nickelO   (nickelO),
      .busy      (busy),
      .done      (done),
      .short     (short),
      .remaining (remaining)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   // Model stock: index 0 quarter, 1 dime, 2 nickel.
   int m_tube[3];
   int exp_coins[$];   // eject vector {q,d,n} per coin in payout order
   int exp_rem;

   task automatic check_eq(input string tag, input int obs, input int expv);
      n_checks++;
      if (obs == expv) n_pass++;
      else $display("FAIL %s: got %0d, want %0d (t=%0t)", tag, obs, expv, $time);
   endtask

   // Greedy payout from the rules: biggest stocked coin that fits, until none does.
   task automatic model_payout(input int amt);
      int rem;
      int val[3]  = '{25, 10, 5};
      int ejv[3]  = '{4, 2, 1};
      bit found;
      rem = amt;
      exp_coins.delete();
      do begin
         found = 1'b0;
         for (int j = 0; j < 3; j++) begin
            if (!found && rem >= val[j] && m_tube[j] > 0) begin
               found = 1'b1;
               rem -= val[j];
               m_tube[j]--;
               exp_coins.push_back(ejv[j]);
            end
         end
      end while (found);
      exp_rem = rem;
   endtask

   task automatic model_refill();
      for (int j = 0; j < 3; j++) m_tube[j] = TUBE_INIT;
   endtask

   // Idle-time refill strobe.
   task automatic do_refill();
      refill = 1'b1;
      @(posedge clk);
      #1;
      refill = 1'b0;
      model_refill();
   endtask

   // Runs one payout, checking every cycle from the first SELECT until back in IDLE.
   // Optional busy-time start/refill strobes and a start+refill collision.
   task automatic run_payout(input int amt, input bit inj_start, input bit inj_refill,
                             input bit with_refill);
      int k, d, off, idx, ph, exp_ej, s_cyc, r_cyc;
      amount = 8'(amt);
      start  = 1'b1;
      refill = with_refill;
      @(posedge clk);
      #1;
      start  = 1'b0;
      refill = 1'b0;
      amount = 8'($urandom);
      model_payout(amt);
      k = exp_coins.size();
      d = k * SLOT + 2;
      s_cyc = inj_start  ? int'($urandom_range(1, d)) : 0;
      r_cyc = inj_refill ? int'($urandom_range(1, d)) : 0;
      for (int c = 1; c <= d + 1; c++) begin
         if (c > 1) begin
            @(posedge clk);
            #1;
            start  = 1'b0;
            refill = 1'b0;
         end
         off    = c - 1;
         idx    = off / SLOT;
         ph     = off % SLOT;
         exp_ej = 0;
         if (c <= d && idx < k && ph >= 1 && ph <= P) exp_ej = exp_coins[idx];
         check_eq("ejects", int'({quarterO, dimeO, nickelO}), exp_ej);
         check_eq("busy", int'(busy), int'(c <= d));
         check_eq("done", int'(done), int'(c == d));
         check_eq("short", int'(short), int'(c == d && exp_rem != 0));
         if (c == 1) check_eq("remaining_start", int'(remaining), amt);
         if (c == d) check_eq("remaining_end", int'(remaining), exp_rem);
         if (c == s_cyc) begin
            start  = 1'b1;
            amount = 8'($urandom_range(1, 255));
         end
         if (c == r_cyc) refill = 1'b1;
      end
      start  = 1'b0;
      refill = 1'b0;
   endtask

   initial begin
      reset  = 1'b1;
      start  = 1'b0;
      refill = 1'b0;
      amount = '0;
      model_refill();
      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_ejects", int'({quarterO, dimeO, nickelO}), 0);
      check_eq("rst_busy", int'(busy), 0);
      check_eq("rst_done", int'(done), 0);
      check_eq("rst_short", int'(short), 0);
      check_eq("rst_remaining", int'(remaining), 0);
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;

      // Quarter, dime, nickel at the reference timing.
      run_payout(40, 0, 0, 0);

      // Drain the quarter tube, then a start+refill collision must not refill.
      do_refill();
      for (int i = 0; i < 20; i++) run_payout(25, 0, 0, 0);
      run_payout(30, 0, 0, 1);

      // Busy-time start and refill are both dropped; dimes stand in for quarters.
      run_payout(65, 1, 1, 0);
      run_payout(25, 0, 0, 0);
      do_refill();
      run_payout(25, 0, 0, 0);

      // Residue forces a shortfall.
      run_payout(7, 0, 0, 0);

      // Reset during the first quarter pulse aborts and restores the tubes.
      amount = 8'd50;
      start  = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_eq("pre_reset_quarter", int'(quarterO), 1);
      #2;
      reset = 1'b1;
      #1;
      check_eq("abort_ejects", int'({quarterO, dimeO, nickelO}), 0);
      check_eq("abort_busy", int'(busy), 0);
      check_eq("abort_done", int'(done), 0);
      check_eq("abort_remaining", int'(remaining), 0);
      model_refill();
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;
      run_payout(50, 0, 0, 0);

      // Zero amount: straight to DONE, no ejects.
      run_payout(0, 0, 0, 0);

      // Random traffic with occasional refills and busy-time strobes.
      for (int i = 0; i < 40; i++) begin
         if ($urandom_range(0, 7) == 0) do_refill();
         run_payout(int'($urandom_range(0, 255)), $urandom_range(0, 3) == 0,
                    $urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
